instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/arm_isa_pkg.sv | 50 +++++
 rtl/instr_fifo.sv | 59 +++++
 rtl/instr_encoder.sv | 102 ++++++++++
 tb/tb_instr_encoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_isa_pkg.sv
// Shared ISA definitions for the instruction encoder slice.
// Contents: op-class encodings (req_kind), DP command codes, fixed opcode
// fields for memory/branch words, the instruction FIFO depth, and a helper
// that classifies DP commands as legal or illegal.
package arm_isa_pkg;

  typedef enum logic [1:0] {
    DP  = 2'b00,
    MEM = 2'b01,
    BR  = 2'b10,
    ILL = 2'b11
  } op_class_e;

  typedef enum logic [3:0] {
    AND    = 4'b0000,
    SUB    = 4'b0010,
    ORR    = 4'b0011,
    ADD    = 4'b0100,
    XOR    = 4'b0101,
    FADD   = 4'b0110,
    FMUL   = 4'b0111,
    VADD   = 4'b1000,
    VSUB   = 4'b1001,
    VAND   = 4'b1010,
    VORR   = 4'b1011,
    VADDFP = 4'b1100,
    MOVIDX = 4'b1101,
    MOV    = 4'b1110,
    VXOR   = 4'b1111
  } cmd_e;

  localparam int unsigned FIFO_DEPTH = 4;

  // Fixed fields inside memory and branch words
  localparam logic [3:0] MEM_FUNCT = 4'b1100;
  localparam logic [3:0] BR_OP     = 4'b1010;

  // Code 0001 is not in cmd_e and always falls to the illegal default.
  function automatic logic dp_cmd_legal(input logic [3:0] cmd, input logic vec_en);
    logic ok;
    ok = 1'b0;
    case (cmd)
      AND, SUB, ORR, ADD, XOR, FADD, FMUL, MOV:       ok = 1'b1;
      VADD, VSUB, VAND, VORR, VADDFP, MOVIDX, VXOR:   ok = vec_en;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO: DEPTH entries of WIDTH bits, first-word-fall-through
// head output (dout is the head entry whenever empty is low).
// Ports:
//   clk, reset      - clock, synchronous active-high reset (empties FIFO)
//   push, din       - write request and data; ignored when full
//   pop             - read request; ignored when empty
//   dout            - head entry
//   full, empty     - status flags
//   level           - occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fifo
  import arm_isa_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [LW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      count <= count + LW'(1);
      else if (do_pop && !do_push) count <= count - LW'(1);
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded request fields, checks legality,
// builds the 32-bit instruction word and queues it in a 4-entry FIFO.
// iw_addr tracks the byte address of the head word (+4 per pop).
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   req_valid/req_ready           - request handshake (ready = FIFO not full)
//   req_kind, req_cmd, req_s, req_imm, req_cond,
//   req_rn, req_rd, req_src2, req_off - request fields
//   iw_valid/iw_ready, iw_data    - encoded word output handshake
//   iw_addr                       - instruction-memory byte address of head
//   err                           - one-cycle pulse after an illegal request
//   level                         - FIFO occupancy 0..4
// Build option: define VEC_EN to accept vector DP commands.
module instr_encoder
  import arm_isa_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [3:0]  req_cmd,
  input  logic        req_s,
  input  logic        req_imm,
  input  logic [3:0]  req_cond,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rd,
  input  logic [11:0] req_src2,
  input  logic [23:0] req_off,
  output logic        iw_valid,
  input  logic        iw_ready,
  output logic [31:0] iw_data,
  output logic [31:0] iw_addr,
  output logic        err,
  output logic [2:0]  level
);

`ifdef VEC_EN
  localparam logic VEC = 1'b1;
`else
  localparam logic VEC = 1'b0;
`endif

  logic        full, empty;
  logic        hs, legal, push, pop;
  logic [31:0] word;

  assign req_ready = !full;
  assign iw_valid  = !empty;
  assign hs        = req_valid && req_ready;
  assign push      = hs && legal;
  assign pop       = iw_valid && iw_ready;

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (op_class_e'(req_kind))
      DP: begin
        word  = {req_cond, 2'b00, req_imm, req_cmd, req_s, req_rn, req_rd, req_src2};
        legal = dp_cmd_legal(req_cmd, VEC);
      end
      MEM: begin
        word  = {req_cond, 2'b01, req_imm, MEM_FUNCT, req_s, req_rn, req_rd, req_src2};
        legal = 1'b1;
      end
      BR: begin
        word  = {req_cond, BR_OP, req_off};
        legal = 1'b1;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err     <= 1'b0;
      iw_addr <= '0;
    end else begin
      err <= hs && !legal;
      if (pop) iw_addr <= iw_addr + 32'd4;
    end
  end

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (word),
    .pop   (pop),
    .dout  (iw_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;
  import arm_isa_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_kind = 2'b00;
  logic [3:0]  req_cmd = 4'b0000;
  logic        req_s = 1'b0;
  logic        req_imm = 1'b0;
  logic [3:0]  req_cond = 4'b0000;
  logic [3:0]  req_rn = 4'b0000;
  logic [3:0]  req_rd = 4'b0000;
  logic [11:0] req_src2 = 12'h000;
  logic [23:0] req_off = 24'h000000;
  logic        iw_valid;
  logic        iw_ready = 1'b0;
  logic [31:0] iw_data;
  logic [31:0] iw_addr;
  logic        err;
  logic [2:0]  level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .req_cmd   (req_cmd),
    .req_s     (req_s),
    .req_imm   (req_imm),
    .req_cond  (req_cond),
    .req_rn    (req_rn),
    .req_rd    (req_rd),
    .req_src2  (req_src2),
    .req_off   (req_off),
    .iw_valid  (iw_valid),
    .iw_ready  (iw_ready),
    .iw_data   (iw_data),
    .iw_addr   (iw_addr),
    .err       (err),
    .level     (level)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] kind, input logic [3:0] cmd, input logic s,
                         input logic [3:0] rn, input logic [3:0] rd,
                         input logic [11:0] src2, input logic [23:0] off);
    req_kind = kind; req_cmd = cmd; req_s = s; req_imm = 1'b0; req_cond = 4'hE;
    req_rn = rn; req_rd = rd; req_src2 = src2; req_off = off;
  endtask

  task automatic send(input logic [1:0] kind, input logic [3:0] cmd, input logic s,
                      input logic [3:0] rn, input logic [3:0] rd,
                      input logic [11:0] src2, input logic [23:0] off);
    set_req(kind, cmd, s, rn, rd, src2, off);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1; req_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; iw_ready = 1'b1;
    tick(); tick();
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
    tests++; if (iw_valid !== 1'b0) begin fails++; $display("FAIL reset_iw_valid got %b want 0", iw_valid); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    tests++; if (iw_addr !== 32'd0) begin fails++; $display("FAIL reset_iw_addr got %h want 0", iw_addr); end
    reset = 1'b0;
  endtask

  task automatic test_dp_add;
    do_reset(); iw_ready = 1'b1;
    send(DP, ADD, 1'b1, 4'd1, 4'd2, 12'h003, 24'h0);
    tests++; if (iw_valid !== 1'b1) begin fails++; $display("FAIL add_valid got %b want 1", iw_valid); end
    tests++; if (iw_data !== 32'hE0912003) begin fails++; $display("FAIL add_data got %h want E0912003", iw_data); end
    tests++; if (iw_addr !== 32'd0) begin fails++; $display("FAIL add_addr got %h want 0", iw_addr); end
    tick();
    tests++; if (iw_addr !== 32'd4) begin fails++; $display("FAIL add_addr_after_pop got %h want 4", iw_addr); end
    tests++; if (iw_valid !== 1'b0) begin fails++; $display("FAIL add_empty got %b want 0", iw_valid); end
  endtask

  task automatic test_mem_branch;
    do_reset(); iw_ready = 1'b0;
    send(MEM, 4'b0000, 1'b1, 4'd3, 4'd4, 12'h008, 24'h0);
    send(BR, 4'b0000, 1'b0, 4'd0, 4'd0, 12'h000, 24'h000010);
    tests++; if (level !== 3'd2) begin fails++; $display("FAIL mb_level got %0d want 2", level); end
    tests++; if (iw_data !== 32'hE5934008) begin fails++; $display("FAIL mb_mem_data got %h want E5934008", iw_data); end
    tests++; if (iw_addr !== 32'd0) begin fails++; $display("FAIL mb_mem_addr got %h want 0", iw_addr); end
    // Held word must not move while iw_ready is low
    tick();
    tests++; if (iw_data !== 32'hE5934008) begin fails++; $display("FAIL mb_stall_data got %h want E5934008", iw_data); end
    iw_ready = 1'b1;
    tick();
    tests++; if (iw_data !== 32'hEA000010) begin fails++; $display("FAIL mb_br_data got %h want EA000010", iw_data); end
    tests++; if (iw_addr !== 32'd4) begin fails++; $display("FAIL mb_br_addr got %h want 4", iw_addr); end
    tick();
    tests++; if (iw_valid !== 1'b0 || iw_addr !== 32'd8) begin
      fails++; $display("FAIL mb_drain got valid=%b addr=%h want valid=0 addr=8", iw_valid, iw_addr);
    end
    // Pop on empty FIFO is ignored
    tick();
    tests++; if (iw_addr !== 32'd8 || level !== 3'd0) begin
      fails++; $display("FAIL mb_empty_pop got addr=%h level=%0d want addr=8 level=0", iw_addr, level);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_w [5];
    int pops;
    logic accepted;
    logic took;
    exp_w[0] = 32'hE0910003; exp_w[1] = 32'hE0911003; exp_w[2] = 32'hE0912003;
    exp_w[3] = 32'hE0913003; exp_w[4] = 32'hE0914003;
    do_reset(); iw_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(DP, ADD, 1'b1, 4'd1, 4'(i), 12'h003, 24'h0);
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_ready got %b want 0", req_ready); end
    tests++; if (level !== 3'd4) begin fails++; $display("FAIL b2b_full_level got %0d want 4", level); end
    // Fifth request waits while full; push is refused even on the first pop cycle
    set_req(DP, ADD, 1'b1, 4'd1, 4'd4, 12'h003, 24'h0);
    req_valid = 1'b1;
    tick();
    tests++; if (level !== 3'd4) begin fails++; $display("FAIL b2b_blocked_level got %0d want 4", level); end
    iw_ready = 1'b1;
    pops = 0; accepted = 1'b0;
    for (int c = 0; c < 16 && pops < 5; c++) begin
      if (iw_valid) begin
        tests++;
        if (iw_data !== exp_w[pops]) begin
          fails++; $display("FAIL b2b_order[%0d] got %h want %h", pops, iw_data, exp_w[pops]);
        end
        pops++;
      end
      took = req_valid && req_ready;
      tick();
      if (took) begin
        req_valid = 1'b0; accepted = 1'b1;
        tests++; if (level !== 3'd3) begin fails++; $display("FAIL b2b_pushpop_level got %0d want 3", level); end
      end
    end
    req_valid = 1'b0;
    tests++; if (pops != 5 || !accepted) begin
      fails++; $display("FAIL b2b_count got pops=%0d accepted=%b want pops=5 accepted=1", pops, accepted);
    end
    tests++; if (iw_addr !== 32'd20) begin fails++; $display("FAIL b2b_addr got %h want 14", iw_addr); end
  endtask

  task automatic test_illegal;
    do_reset(); iw_ready = 1'b1;
    send(ILL, ADD, 1'b0, 4'd0, 4'd0, 12'h000, 24'h0);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL ill_kind_err got %b want 1", err); end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL ill_kind_level got %0d want 0", level); end
    tick();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL ill_kind_pulse got %b want 0", err); end
    send(DP, 4'b0001, 1'b1, 4'd1, 4'd2, 12'h003, 24'h0);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL ill_cmd_err got %b want 1", err); end
    tests++; if (level !== 3'd0 || iw_addr !== 32'd0) begin
      fails++; $display("FAIL ill_cmd_state got level=%0d addr=%h want 0 0", level, iw_addr);
    end
    tick();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL ill_cmd_pulse got %b want 0", err); end
  endtask

  task automatic test_vec;
    do_reset(); iw_ready = 1'b0;
    send(DP, VADD, 1'b1, 4'd1, 4'd2, 12'h003, 24'h0);
`ifdef VEC_EN
    tests++; if (err !== 1'b0 || level !== 3'd1) begin
      fails++; $display("FAIL vec_enq got err=%b level=%0d want err=0 level=1", err, level);
    end
    tests++; if (iw_data !== 32'hE1112003) begin fails++; $display("FAIL vec_data got %h want E1112003", iw_data); end
`else
    tests++; if (err !== 1'b1 || level !== 3'd0) begin
      fails++; $display("FAIL vec_reject got err=%b level=%0d want err=1 level=0", err, level);
    end
`endif
    // Plain legal DP commands still pass
    send(DP, MOV, 1'b0, 4'd0, 4'd5, 12'h0FF, 24'h0);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL vec_mov_err got %b want 0", err); end
  endtask

  task automatic test_reset_midstream;
    do_reset(); iw_ready = 1'b1;
    send(DP, ADD, 1'b1, 4'd1, 4'd2, 12'h003, 24'h0);
    tick();
    send(DP, SUB, 1'b0, 4'd1, 4'd2, 12'h003, 24'h0);
    tick();
    iw_ready = 1'b0;
    send(DP, AND, 1'b0, 4'd1, 4'd2, 12'h003, 24'h0);
    send(DP, ORR, 1'b0, 4'd1, 4'd2, 12'h003, 24'h0);
    tests++; if (level !== 3'd2 || iw_addr !== 32'd8) begin
      fails++; $display("FAIL mid_setup got level=%0d addr=%h want 2 8", level, iw_addr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (level !== 3'd0 || iw_valid !== 1'b0 || iw_addr !== 32'd0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset got level=%0d valid=%b addr=%h ready=%b want 0 0 0 1",
                        level, iw_valid, iw_addr, req_ready);
    end
    send(DP, ADD, 1'b1, 4'd1, 4'd2, 12'h003, 24'h0);
    tests++; if (iw_data !== 32'hE0912003 || iw_addr !== 32'd0 || level !== 3'd1) begin
      fails++; $display("FAIL mid_after got data=%h addr=%h level=%0d want E0912003 0 1",
                        iw_data, iw_addr, level);
    end
  endtask

  initial begin
    test_reset();
    test_dp_add();
    test_mem_branch();
    test_back_to_back();
    test_illegal();
    test_vec();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
